// File: rtl/ahb_manager.sv
// AHB-Lite manager: local command/response front end driving a two-slot
// (address phase / data phase) pipeline with ERROR-driven park and reissue.
module ahb_manager #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  hsel_x,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [1:0]            htrans,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hrdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Address slot: haddr/hwrite/hsize double as its addr/write/size fields.
    logic                  vld_p0;
    logic                  park_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic                  vld_p0_nx;
    logic                  park_p0_nx;

    // Data slot: hwdata doubles as its wdata field.
    logic                  vld_p1;
    logic                  write_p1;

    logic                  a_done;
    logic                  d_done;
    logic                  err_first;
    logic                  cmd_acc;

    assign a_done    = vld_p0 && !park_p0 && hready;
    assign d_done    = vld_p1 && hready;
    assign err_first = vld_p1 && hresp && !hready;
    assign cmd_ready = hreset_n && (!vld_p0 || a_done);
    assign cmd_acc   = cmd_valid && cmd_ready;

    // A command landing in the error-first cycle must also sit out the
    // error-second cycle, so it is loaded already parked.
    always_comb begin
        vld_p0_nx  = vld_p0;
        park_p0_nx = park_p0;
        if (cmd_acc) begin
            vld_p0_nx  = 1'b1;
            park_p0_nx = err_first;
        end else if (a_done) begin
            vld_p0_nx  = 1'b0;
            park_p0_nx = 1'b0;
        end else if (vld_p0 && park_p0 && hready) begin
            park_p0_nx = 1'b0;
        end else if (vld_p0 && err_first) begin
            park_p0_nx = 1'b1;
        end
    end

    // ---- p0 -> p1 data fields (no reset needed, qualified by valid flags)
    always_ff @(posedge hclk) begin
        if (cmd_acc) begin
            wdata_p0 <= cmd_wdata;
        end
        if (a_done) begin
            write_p1 <= hwrite;
        end
    end

    // ---- p0 address phase / p1 data phase / p2 response
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            vld_p0    <= 1'b0;
            park_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hsel_x    <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'd0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            vld_p0  <= vld_p0_nx;
            park_p0 <= park_p0_nx;
            htrans  <= (vld_p0_nx && !park_p0_nx) ? HTRANS_NONSEQ : HTRANS_IDLE;
            hsel_x  <= vld_p0_nx && !park_p0_nx;
            if (cmd_acc) begin
                haddr  <= cmd_addr;
                hwrite <= cmd_write;
                hsize  <= cmd_size;
            end

            if (a_done) begin
                vld_p1 <= 1'b1;
                if (hwrite) begin
                    hwdata <= wdata_p0;
                end
            end else if (d_done) begin
                vld_p1 <= 1'b0;
            end

            rsp_valid <= d_done;
            if (d_done) begin
                rsp_write <= write_p1;
                rsp_rdata <= write_p1 ? '0 : hrdata;
                rsp_err   <= hresp;
            end
        end
    end

endmodule

// File: tb/tb_ahb_manager.sv
// Bench for ahb_manager: directed scenarios plus a randomized run against a
// command-order reference model and a small AHB slave model.
module tb_ahb_manager;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int N  = 200;

    logic          hclk = 1'b0;
    logic          hreset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic          hsel_x;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [28:0]   all_outs;

    int vectors     = 0;
    int miscompares = 0;

    assign all_outs = {htrans, hsel_x, haddr, hwrite, hsize, hwdata,
                       rsp_valid, rsp_write, rsp_rdata, rsp_err};

    always #8 hclk = ~hclk;

    ahb_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .hsel_x(hsel_x), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = 3'd0;
        cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    endtask

    task automatic put_cmd(input logic w, input logic [AW-1:0] a,
                           input logic [2:0] s, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        idle_inputs();
        cmd_valid = 1'b1;
        repeat (3) @(negedge hclk);
        vectors++;
        if (all_outs !== '0) begin
            miscompares++; $display("FAIL reset_outs: got %h, want 0", all_outs);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got %b, want 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        hreset_n  = 1'b1;
        @(negedge hclk);
        vectors++;
        if ({htrans, hsel_x, cmd_ready} !== 4'b0001) begin
            miscompares++; $display("FAIL post_reset_idle: got %b, want 0001", {htrans, hsel_x, cmd_ready});
        end
    endtask

    task automatic test_write();
        @(negedge hclk);
        put_cmd(1'b1, 3'd4, 3'd0, 8'd12);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL wr_ready: got %b, want 1", cmd_ready);
        end
        @(negedge hclk);
        cmd_valid = 1'b0;
        vectors++;
        if ({htrans, hsel_x, haddr, hwrite, hsize} !== {2'b10, 1'b1, 3'd4, 1'b1, 3'd0}) begin
            miscompares++; $display("FAIL wr_aphase: got %b, want 10_1_100_1_000", {htrans, hsel_x, haddr, hwrite, hsize});
        end
        @(negedge hclk);
        vectors++;
        if ({htrans, hsel_x, hwdata, rsp_valid} !== {2'b00, 1'b0, 8'd12, 1'b0}) begin
            miscompares++; $display("FAIL wr_dphase: got %h, want %h", {htrans, hsel_x, hwdata, rsp_valid}, {2'b00, 1'b0, 8'd12, 1'b0});
        end
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            miscompares++; $display("FAIL wr_rsp: got %h, want %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, 1'b1, 1'b0, 8'd0});
        end
        @(negedge hclk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL wr_rsp_pulse: got %b, want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge hclk);
        put_cmd(1'b1, 3'd2, 3'd1, 8'h29);
        @(negedge hclk);
        vectors++;
        if ({htrans, haddr, hsize} !== {2'b10, 3'd2, 3'd1}) begin
            miscompares++; $display("FAIL b2b_aph1: got %b, want 10_010_001", {htrans, haddr, hsize});
        end
        put_cmd(1'b1, 3'd3, 3'd0, 8'h0D);
        hready = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready: got %b, want 1", cmd_ready);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge hclk);
            cmd_valid = 1'b0;
            vectors++;
            if ({htrans, haddr, hwrite, hwdata, rsp_valid} !== {2'b10, 3'd3, 1'b1, 8'h29, 1'b0}) begin
                miscompares++; $display("FAIL b2b_hold%0d: got %h, want %h", w, {htrans, haddr, hwrite, hwdata, rsp_valid}, {2'b10, 3'd3, 1'b1, 8'h29, 1'b0});
            end
            hready = (w == 2);
        end
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err, htrans, hwdata} !== {1'b1, 1'b1, 1'b0, 2'b00, 8'h0D}) begin
            miscompares++; $display("FAIL b2b_rsp1: got %h, want %h", {rsp_valid, rsp_write, rsp_err, htrans, hwdata}, {1'b1, 1'b1, 1'b0, 2'b00, 8'h0D});
        end
        hready = 1'b1;
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin
            miscompares++; $display("FAIL b2b_rsp2: got %b, want 110", {rsp_valid, rsp_write, rsp_err});
        end
        @(negedge hclk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_rsp_end: got %b, want 0", rsp_valid);
        end
    endtask

    task automatic test_read();
        @(negedge hclk);
        put_cmd(1'b0, 3'd4, 3'd0, 8'hA5);
        @(negedge hclk);
        cmd_valid = 1'b0;
        vectors++;
        if ({htrans, haddr, hwrite} !== {2'b10, 3'd4, 1'b0}) begin
            miscompares++; $display("FAIL rd_aphase: got %b, want 10_100_0", {htrans, haddr, hwrite});
        end
        @(negedge hclk);
        vectors++;
        if (hwdata !== 8'h0D) begin
            miscompares++; $display("FAIL rd_hwdata_kept: got %h, want 0d", hwdata);
        end
        hrdata = 8'd12;
        @(negedge hclk);
        hrdata = 8'd0;
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 8'd12}) begin
            miscompares++; $display("FAIL rd_rsp: got %h, want %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 8'd12});
        end
    endtask

    task automatic test_error();
        @(negedge hclk);
        put_cmd(1'b1, 3'd1, 3'd0, 8'h55);
        @(negedge hclk);
        put_cmd(1'b0, 3'd4, 3'd0, 8'h00);
        @(negedge hclk);
        cmd_valid = 1'b0;
        vectors++;
        if ({htrans, haddr, hwrite, hwdata} !== {2'b10, 3'd4, 1'b0, 8'h55}) begin
            miscompares++; $display("FAIL err_setup: got %h, want %h", {htrans, haddr, hwrite, hwdata}, {2'b10, 3'd4, 1'b0, 8'h55});
        end
        hready = 1'b0; hresp = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL err_first_ready: got %b, want 0", cmd_ready);
        end
        @(negedge hclk);
        vectors++;
        if ({htrans, hsel_x, rsp_valid} !== 4'b0000) begin
            miscompares++; $display("FAIL err_idle: got %b, want 0000", {htrans, hsel_x, rsp_valid});
        end
        hready = 1'b1; hresp = 1'b1;
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err, htrans, hsel_x, haddr, hwrite} !== {3'b111, 2'b10, 1'b1, 3'd4, 1'b0}) begin
            miscompares++; $display("FAIL err_rsp_reissue: got %b, want 111_10_1_100_0", {rsp_valid, rsp_write, rsp_err, htrans, hsel_x, haddr, hwrite});
        end
        hresp = 1'b0;
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, htrans} !== 3'b000) begin
            miscompares++; $display("FAIL err_after_reissue: got %b, want 000", {rsp_valid, htrans});
        end
        hrdata = 8'd12;
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 8'd12}) begin
            miscompares++; $display("FAIL err_rsp2: got %h, want %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 8'd12});
        end
        @(negedge hclk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL err_rsp_end: got %b, want 0", rsp_valid);
        end
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            @(negedge hclk);
            vectors++;
            if ({htrans, hsel_x, rsp_valid} !== 4'b0000) begin
                miscompares++; $display("FAIL idle_bus%0d: got %b, want 0000", i, {htrans, hsel_x, rsp_valid});
            end
            hready = 1'($urandom_range(0, 1));
            hresp  = 1'($urandom_range(0, 1));
        end
        hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge hclk);
        put_cmd(1'b0, 3'd4, 3'd0, 8'h00);
        @(posedge hclk);
        #1;
        cmd_valid = 1'b0;
        vectors++;
        if ({htrans, hsel_x, haddr} !== {2'b10, 1'b1, 3'd4}) begin
            miscompares++; $display("FAIL rstm_nonseq: got %b, want 10_1_100", {htrans, hsel_x, haddr});
        end
        #9;
        hreset_n  = 1'b0;
        cmd_valid = 1'b1;
        #1;
        vectors++;
        if ({all_outs, cmd_ready} !== '0) begin
            miscompares++; $display("FAIL rstm_immediate: got %h, want 0", {all_outs, cmd_ready});
        end
        #30;
        vectors++;
        if ({all_outs, cmd_ready} !== '0) begin
            miscompares++; $display("FAIL rstm_held: got %h, want 0", {all_outs, cmd_ready});
        end
        cmd_valid = 1'b0;
        #19;
        hreset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            vectors++;
            if ({rsp_valid, htrans} !== 3'b000) begin
                miscompares++; $display("FAIL rstm_no_rsp%0d: got %b, want 000", i, {rsp_valid, htrans});
            end
        end
        put_cmd(1'b1, 3'd2, 3'd0, 8'h77);
        @(negedge hclk);
        cmd_valid = 1'b0;
        vectors++;
        if ({htrans, haddr} !== {2'b10, 3'd2}) begin
            miscompares++; $display("FAIL rstm_aph: got %b, want 10_010", {htrans, haddr});
        end
        @(negedge hclk);
        vectors++;
        if ({hwdata, rsp_valid} !== {8'h77, 1'b0}) begin
            miscompares++; $display("FAIL rstm_dph: got %h, want %h", {hwdata, rsp_valid}, {8'h77, 1'b0});
        end
        @(negedge hclk);
        vectors++;
        if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin
            miscompares++; $display("FAIL rstm_rsp: got %b, want 110", {rsp_valid, rsp_write, rsp_err});
        end
        @(negedge hclk);
    endtask

    task automatic test_random();
        logic          c_write [N];
        logic [AW-1:0] c_addr  [N];
        logic [2:0]    c_size  [N];
        logic [DW-1:0] c_wdata [N];
        int            c_wait  [N];
        logic          c_err   [N];
        logic [DW-1:0] e_rdata [N];
        logic [DW-1:0] ref_mem [8];
        logic [DW-1:0] slv_mem [8];
        int            next_cmd, aph_cnt, rsp_cnt, cycles, dph_idx, dph_waits;
        logic          dph_vld, dph_write, dph_err, err_second, rsp_due;
        logic [AW-1:0] dph_addr;

        for (int a = 0; a < 8; a++) begin
            ref_mem[a] = DW'($urandom);
            slv_mem[a] = ref_mem[a];
        end
        for (int i = 0; i < N; i++) begin
            c_write[i] = 1'($urandom_range(0, 1));
            c_addr[i]  = AW'($urandom_range(0, 7));
            c_size[i]  = 3'($urandom_range(0, 7));
            c_wdata[i] = DW'($urandom);
            c_wait[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            c_err[i]   = ($urandom_range(0, 5) == 0);
        end
        // Reference: responses follow command order; failed writes leave memory alone.
        for (int i = 0; i < N; i++) begin
            if (c_write[i]) begin
                e_rdata[i] = '0;
                if (!c_err[i]) ref_mem[c_addr[i]] = c_wdata[i];
            end else begin
                e_rdata[i] = ref_mem[c_addr[i]];
            end
        end

        next_cmd = 0; aph_cnt = 0; rsp_cnt = 0; cycles = 0; dph_idx = 0; dph_waits = 0;
        dph_vld = 1'b0; dph_write = 1'b0; dph_err = 1'b0; err_second = 1'b0; rsp_due = 1'b0;
        dph_addr = '0;
        while (rsp_cnt < N && cycles < 6000) begin
            @(negedge hclk);
            cycles++;
            vectors++;
            if (rsp_valid !== rsp_due) begin
                miscompares++; $display("FAIL rnd_rsp_timing cyc %0d: got %b, want %b", cycles, rsp_valid, rsp_due);
            end
            if (rsp_valid === 1'b1 && rsp_cnt < N) begin
                vectors++;
                if ({rsp_write, rsp_rdata, rsp_err} !== {c_write[rsp_cnt], e_rdata[rsp_cnt], c_err[rsp_cnt]}) begin
                    miscompares++; $display("FAIL rnd_rsp #%0d: got %h, want %h", rsp_cnt, {rsp_write, rsp_rdata, rsp_err}, {c_write[rsp_cnt], e_rdata[rsp_cnt], c_err[rsp_cnt]});
                end
                rsp_cnt++;
            end
            rsp_due = 1'b0;
            if (dph_vld && err_second) begin
                vectors++;
                if ({htrans, hsel_x} !== 3'b000) begin
                    miscompares++; $display("FAIL rnd_err_idle #%0d: got %b, want 000", dph_idx, {htrans, hsel_x});
                end
            end

            if (dph_vld) begin
                hrdata = slv_mem[dph_addr];
                if (dph_waits > 0)               {hready, hresp} = 2'b00;
                else if (dph_err && !err_second) {hready, hresp} = 2'b01;
                else if (dph_err)                {hready, hresp} = 2'b11;
                else                             {hready, hresp} = 2'b10;
            end else begin
                hrdata = DW'($urandom);
                hready = (htrans == 2'b10) ? 1'b1 : 1'($urandom_range(0, 1));
                hresp  = (htrans == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (next_cmd < N && $urandom_range(0, 3) != 0) begin
                put_cmd(c_write[next_cmd], c_addr[next_cmd], c_size[next_cmd], c_wdata[next_cmd]);
            end else begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = AW'($urandom);
                cmd_size  = 3'($urandom);
                cmd_wdata = DW'($urandom);
            end
            #1;
            if (cmd_valid && cmd_ready) next_cmd++;

            // What the coming edge does, seen from the slave side.
            if (dph_vld) begin
                if (hready) begin
                    if (dph_write) begin
                        vectors++;
                        if (hwdata !== c_wdata[dph_idx]) begin
                            miscompares++; $display("FAIL rnd_hwdata #%0d: got %h, want %h", dph_idx, hwdata, c_wdata[dph_idx]);
                        end
                        if (!dph_err) slv_mem[dph_addr] = hwdata;
                    end
                    rsp_due = 1'b1;
                    dph_vld = 1'b0;
                end else if (dph_waits > 0) begin
                    dph_waits--;
                end else begin
                    err_second = 1'b1;
                end
            end
            if (htrans == 2'b10 && hsel_x && hready) begin
                vectors++;
                if (aph_cnt >= N) begin
                    miscompares++; $display("FAIL rnd_extra_aph: got %0d address phases, want %0d", aph_cnt + 1, N);
                end else begin
                    if ({haddr, hwrite, hsize} !== {c_addr[aph_cnt], c_write[aph_cnt], c_size[aph_cnt]}) begin
                        miscompares++; $display("FAIL rnd_aph #%0d: got %b, want %b", aph_cnt, {haddr, hwrite, hsize}, {c_addr[aph_cnt], c_write[aph_cnt], c_size[aph_cnt]});
                    end
                    dph_vld    = 1'b1;
                    dph_idx    = aph_cnt;
                    dph_write  = hwrite;
                    dph_addr   = haddr;
                    dph_waits  = c_wait[aph_cnt];
                    dph_err    = c_err[aph_cnt];
                    err_second = 1'b0;
                end
                aph_cnt++;
            end
        end
        cmd_valid = 1'b0;
        vectors++;
        if (rsp_cnt != N) begin
            miscompares++; $display("FAIL rnd_timeout: got %0d responses, want %0d", rsp_cnt, N);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_error();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
